// File: rtl/ws2812_rx.sv
// ws2812_rx: receive-side decoder for a single-wire WS2812-style LED data line.
//
// The line is synchronized, each high pulse is measured and classified as a 0 or 1
// bit, and bits are assembled MSB first into BITS_PER_LED-bit words. A low period of
// T_RESET cycles marks the latch gap that ends a frame.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   din         asynchronous LED data line
//   data        last completed word
//   data_valid  one-cycle pulse when data updates
//   led_count   words completed in the current frame (saturating)
//   frame_done  one-cycle pulse on a latch gap that follows at least one whole word
//   error       one-cycle pulse on a protocol violation
module ws2812_rx #(
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned LED_CNT_W    = 8,
  parameter int unsigned T_MIN_HIGH   = 2,
  parameter int unsigned T_THRESH     = 6,
  parameter int unsigned T_MAX_HIGH   = 12,
  parameter int unsigned T_RESET      = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din,
  output logic [BITS_PER_LED-1:0] data,
  output logic                    data_valid,
  output logic [LED_CNT_W-1:0]    led_count,
  output logic                    frame_done,
  output logic                    error
);

  localparam int unsigned BitCntW = $clog2(BITS_PER_LED + 1);

  localparam logic [CNT_W-1:0]   CntMax    = '1;
  localparam logic [CNT_W-1:0]   TMinHigh  = CNT_W'(T_MIN_HIGH);
  localparam logic [CNT_W-1:0]   TThresh   = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0]   TMaxHigh  = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0]   TReset    = CNT_W'(T_RESET);
  localparam logic [BitCntW-1:0] BitsLast  = BitCntW'(BITS_PER_LED - 1);

  typedef enum logic [1:0] {
    StWaitGap,
    StIdle,
    StHigh,
    StLow
  } state_e;

  // Synchronizer and edge detection
  logic din_meta;
  logic din_s;
  logic din_prev;
  logic rise;
  logic fall;

  // Decoder state
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        hcnt_q, hcnt_d;
  logic [CNT_W-1:0]        lcnt_q, lcnt_d;
  logic [BITS_PER_LED-1:0] shreg_q, shreg_d;
  logic [BitCntW-1:0]      bitcnt_q, bitcnt_d;

  // Output registers
  logic [BITS_PER_LED-1:0] data_q;
  logic                    data_valid_q;
  logic [LED_CNT_W-1:0]    led_count_q, led_count_d;
  logic                    frame_done_q;
  logic                    error_q;

  // Single-cycle events from the decoder
  logic                    word_done;
  logic                    frame_end;
  logic                    err_set;
  logic                    bit_val;
  logic [CNT_W-1:0]        hcnt_inc;
  logic [CNT_W-1:0]        lcnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer: din_s lags din by two cycles; din_prev supports edge
  // detection on the synchronized signal only.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_prev <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
      din_prev <= din_s;
    end
  end

  assign rise = din_s & ~din_prev;
  assign fall = ~din_s & din_prev;

  // ---------------------------------------------------------------------------
  // Decoder state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StWaitGap;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    word_done = 1'b0;
    frame_end = 1'b0;
    err_set   = 1'b0;
    hcnt_inc  = sat_inc(hcnt_q);
    lcnt_inc  = sat_inc(lcnt_q);
    // hcnt_q holds the number of high cycles seen so far, including the rise cycle
    bit_val   = (hcnt_q >= TThresh);

    unique case (state_q)
      // Only a full latch gap lets decoding start, so a mid-frame attach
      // never produces misaligned words.
      StWaitGap: begin
        if (din_s) begin
          lcnt_d = '0;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc >= TReset) begin
            state_d = StIdle;
            lcnt_d  = '0;
          end
        end
      end

      StIdle: begin
        if (rise) begin
          state_d = StHigh;
          hcnt_d  = CNT_W'(1);
        end
      end

      StHigh: begin
        if (din_s) begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc > TMaxHigh) begin
            err_set = 1'b1;
            state_d = StWaitGap;
            lcnt_d  = '0;
          end
        end else if (fall) begin
          if (hcnt_q < TMinHigh) begin
            err_set = 1'b1;
            state_d = StWaitGap;
            lcnt_d  = '0;
          end else begin
            shreg_d = {shreg_q[BITS_PER_LED-2:0], bit_val};
            if (bitcnt_q == BitsLast) begin
              word_done = 1'b1;
              bitcnt_d  = '0;
            end else begin
              bitcnt_d = bitcnt_q + BitCntW'(1);
            end
            state_d = StLow;
            // The falling-edge cycle is the first low cycle
            lcnt_d  = CNT_W'(1);
          end
        end
      end

      StLow: begin
        if (rise) begin
          state_d = StHigh;
          hcnt_d  = CNT_W'(1);
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc >= TReset) begin
            state_d = StIdle;
            if (bitcnt_q == '0) begin
              frame_end = 1'b1;
            end else begin
              // Latch gap inside a word: the partial word is a protocol error
              err_set = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = StWaitGap;
        lcnt_d  = '0;
      end
    endcase

    // Any error discards partially assembled bits
    if (err_set) begin
      shreg_d  = '0;
      bitcnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Word counter: holds through the frame_done pulse and clears the cycle after,
  // so a consumer can read the frame length alongside frame_done.
  // ---------------------------------------------------------------------------
  always_comb begin
    led_count_d = led_count_q;
    if (err_set) begin
      led_count_d = '0;
    end else if (word_done) begin
      led_count_d = (led_count_q == '1) ? led_count_q : led_count_q + LED_CNT_W'(1);
    end else if (frame_done_q) begin
      led_count_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      led_count_q  <= '0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (word_done) begin
        data_q <= shreg_d;
      end
      data_valid_q <= word_done;
      led_count_q  <= led_count_d;
      frame_done_q <= frame_end;
      error_q      <= err_set;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign led_count  = led_count_q;
  assign frame_done = frame_done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx. Expected words and expected frame
// lengths are queued when stimulus is driven and compared when the decoder reports.
module tb_ws2812_rx;

  localparam int unsigned Bits = 24;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            din = 1'b0;
  logic [Bits-1:0] data;
  logic            data_valid;
  logic [7:0]      led_count;
  logic            frame_done;
  logic            error;

  int tests = 0;
  int fails = 0;
  int dv_cnt = 0;
  int fd_cnt = 0;
  int err_cnt = 0;

  logic [Bits-1:0] exp_q[$];
  int              fd_q[$];

  ws2812_rx dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .data      (data),
    .data_valid(data_valid),
    .led_count (led_count),
    .frame_done(frame_done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      if (exp_q.size() == 0) check("unexpected_data_valid", 32'd1, 32'd0);
      else check("data", 32'(data), 32'(exp_q.pop_front()));
    end
    if (frame_done) begin
      fd_cnt++;
      if (fd_q.size() == 0) check("unexpected_frame_done", 32'd1, 32'd0);
      else check("frame_done_led_count", 32'(led_count), 32'(fd_q.pop_front()));
    end
    if (data_valid || frame_done) check("dv_fd_exclusive", 32'(data_valid & frame_done), 32'd0);
    if (error) err_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    din = 1'b1;
    cycles(h);
    din = 1'b0;
    cycles(l);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(8, 4);
    else pulse(4, 8);
  endtask

  // Sends the top n bits of w, MSB first
  task automatic send_bits(input logic [Bits-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[Bits-1-i]);
  endtask

  task automatic send_word(input logic [Bits-1:0] w, input logic expect_it);
    if (expect_it) exp_q.push_back(w);
    send_bits(w, Bits);
  endtask

  int dv0, fd0, er0;
  logic [Bits-1:0] boundary_tail;

  initial begin
    // Reset state
    reset = 1'b1;
    din   = 1'b0;
    cycles(3);
    check("reset_data", 32'(data), 32'd0);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_led_count", 32'(led_count), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    reset = 1'b0;

    // Single word frame
    cycles(500);
    send_word(24'hA5C3F0, 1'b1);
    #1;
    check("single_led_count", 32'(led_count), 32'd1);
    check("single_dv_cnt", 32'(dv_cnt), 32'd1);
    fd_q.push_back(1);
    cycles(600);
    #1;
    check("single_led_count_cleared", 32'(led_count), 32'd0);
    check("single_fd_cnt", 32'(fd_cnt), 32'd1);
    check("single_err_cnt", 32'(err_cnt), 32'd0);

    // Three words back to back
    dv0 = dv_cnt;
    fd0 = fd_cnt;
    send_word(24'hFF0000, 1'b1);
    send_word(24'h00FF00, 1'b1);
    send_word(24'h0000FF, 1'b1);
    fd_q.push_back(3);
    cycles(600);
    #1;
    check("three_dv_cnt", 32'(dv_cnt - dv0), 32'd3);
    check("three_fd_cnt", 32'(fd_cnt - fd0), 32'd1);
    check("three_led_count_cleared", 32'(led_count), 32'd0);

    // Pulse-length boundaries: 2 -> 0, 5 -> 0, 6 -> 1, 12 -> 1
    boundary_tail = 24'hABCDE0;
    exp_q.push_back(24'h3ABCDE);
    pulse(2, 4);
    pulse(5, 4);
    pulse(6, 4);
    pulse(12, 4);
    send_bits(boundary_tail, 20);
    fd_q.push_back(1);
    cycles(600);
    #1;
    check("boundary_err_cnt", 32'(err_cnt), 32'd0);
    check("boundary_fd_cnt", 32'(fd_cnt), 32'd3);

    // One-cycle glitch, then a word without a full gap is ignored
    dv0 = dv_cnt;
    fd0 = fd_cnt;
    er0 = err_cnt;
    pulse(1, 100);
    #1;
    check("glitch_error", 32'(err_cnt - er0), 32'd1);
    send_word(24'h123456, 1'b0);
    cycles(600);
    #1;
    check("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_no_fd", 32'(fd_cnt - fd0), 32'd0);
    check("glitch_single_error", 32'(err_cnt - er0), 32'd1);
    send_word(24'h5A5A5A, 1'b1);
    fd_q.push_back(1);
    cycles(600);
    #1;
    check("recover_dv", 32'(dv_cnt - dv0), 32'd1);

    // High held too long: error must appear while din is still high
    dv0 = dv_cnt;
    er0 = err_cnt;
    din = 1'b1;
    cycles(18);
    #1;
    check("long_high_error", 32'(err_cnt - er0), 32'd1);
    check("long_high_din", 32'(din), 32'd1);
    cycles(2);
    din = 1'b0;
    cycles(10);
    // Decoder is waiting for a gap, so this word is ignored
    send_word(24'h777777, 1'b0);
    cycles(600);
    #1;
    check("long_high_wait_gap", 32'(dv_cnt - dv0), 32'd0);
    check("long_high_single_error", 32'(err_cnt - er0), 32'd1);

    // One word then a partial word of 10 bits before the gap
    dv0 = dv_cnt;
    fd0 = fd_cnt;
    er0 = err_cnt;
    send_word(24'h81C37E, 1'b1);
    send_bits(24'hFFC000, 10);
    #1;
    check("partial_led_count_before", 32'(led_count), 32'd1);
    cycles(600);
    #1;
    check("partial_error", 32'(err_cnt - er0), 32'd1);
    check("partial_no_fd", 32'(fd_cnt - fd0), 32'd0);
    check("partial_led_count", 32'(led_count), 32'd0);
    check("partial_dv", 32'(dv_cnt - dv0), 32'd1);

    // Reset asserted mid-word
    send_word(24'h0F0F0F, 1'b1);
    send_bits(24'hF00000, 8);
    din   = 1'b1;
    cycles(3);
    reset = 1'b1;
    din   = 1'b0;
    cycles(1);
    check("midreset_data", 32'(data), 32'd0);
    check("midreset_led_count", 32'(led_count), 32'd0);
    check("midreset_data_valid", 32'(data_valid), 32'd0);
    reset = 1'b0;

    // Immediately after reset there is no gap yet: this word is ignored
    dv0 = dv_cnt;
    fd0 = fd_cnt;
    er0 = err_cnt;
    send_word(24'h111111, 1'b0);
    cycles(600);
    #1;
    check("midstart_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("midstart_no_fd", 32'(fd_cnt - fd0), 32'd0);
    check("midstart_no_err", 32'(err_cnt - er0), 32'd0);
    send_word(24'hC0FFEE, 1'b1);
    fd_q.push_back(1);
    cycles(600);
    #1;
    check("final_dv", 32'(dv_cnt - dv0), 32'd1);
    check("final_fd", 32'(fd_cnt - fd0), 32'd1);

    check("scoreboard_words_left", 32'(exp_q.size()), 32'd0);
    check("scoreboard_frames_left", 32'(fd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
